mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arb_pkg.sv | 43 ++++
 rtl/mem_arb_rr.sv | 19 +
 rtl/mem_arbiter.sv | 167 ++++++++++++++++
 tb/tb_mem_arbiter.sv | 282 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arb_pkg.sv
// Shared definitions for the two-port memory arbiter: size codes, FSM states,
// port identifiers and the alignment rule used by MEM_ARB_ALIGN_CHK_EN builds.
package mem_arb_pkg;

    localparam logic [1:0] SZ_NONE = 2'b00;
    localparam logic [1:0] SZ_BYTE = 2'b01;
    localparam logic [1:0] SZ_HALF = 2'b10;
    localparam logic [1:0] SZ_WORD = 2'b11;

    localparam int   NUM_PORTS = 2;
    localparam logic PORT_I    = 1'b0;
    localparam logic PORT_D    = 1'b1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADDR = 2'd1,
        RESP = 2'd2,
        DONE = 2'd3
    } arb_state_t;

    // Snapshot of the granted request, held for the whole transaction.
    typedef struct packed {
        logic        port;
        logic [31:0] addr;
        logic        rw;
        logic [1:0]  size;
        logic [31:0] wdata;
        logic        bad;
    } arb_req_t;

    // Only the two low address bits matter for alignment.
    function automatic logic is_misaligned(input logic [1:0] addr_lo, input logic [1:0] size);
        logic res;
        case (size)
            SZ_NONE: res = 1'b1;
            SZ_HALF: res = addr_lo[0];
            SZ_WORD: res = (addr_lo != 2'b00);
            default: res = 1'b0;
        endcase
        return res;
    endfunction

endpackage

// File: rtl/mem_arb_rr.sv
// Combinational 2-way round-robin picker: on contention the port that was not
// granted last wins; a lone requester always wins.
module mem_arb_rr
    import mem_arb_pkg::*;
(
    input  logic [1:0] req,
    input  logic       last_grant,
    output logic [1:0] grant
);

    genvar gi;
    generate
        for (gi = 0; gi < NUM_PORTS; gi++) begin : g_pick
            localparam logic PID = (gi == 1);
            assign grant[gi] = req[gi] & (~req[1 - gi] | (last_grant != PID));
        end
    endgenerate

endmodule

// File: rtl/mem_arbiter.sv
// Two-port (fetch I / data D) memory bus arbiter with a 4-state FSM and
// registered outputs. Define MEM_ARB_ALIGN_CHK_EN to reject misaligned requests.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter logic INIT_PRIO_D = 1'b1
)
(
    input  logic        clk,
    input  logic        rst,

    input  logic        i_req,
    input  logic [31:0] i_addr,
    input  logic [1:0]  i_size,
    output logic        i_ack,
    output logic [31:0] i_rdata,

    input  logic        d_req,
    input  logic [31:0] d_addr,
    input  logic        d_rw,
    input  logic [1:0]  d_size,
    input  logic [31:0] d_wdata,
    output logic        d_ack,
    output logic [31:0] d_rdata,

    output logic        err,

    output logic [31:0] bus_addr,
    output logic        bus_rw,
    output logic [1:0]  bus_size,
    output logic [31:0] bus_wdata,
    input  logic [31:0] bus_rdata
);

    arb_state_t  state_reg;
    logic        last_grant_reg;
    arb_req_t    lat_reg;
    arb_req_t    winner;
    logic [1:0]  grant;

    logic [31:0] bus_addr_reg;
    logic        bus_rw_reg;
    logic [1:0]  bus_size_reg;
    logic [31:0] bus_wdata_reg;

    mem_arb_rr u_rr (
        .req        ({d_req, i_req}),
        .last_grant (last_grant_reg),
        .grant      (grant)
    );

    // Operands of whichever port the picker selected; fetches never write.
    always_comb begin
        winner = '0;
        if (grant[PORT_D]) begin
            winner.port  = PORT_D;
            winner.addr  = d_addr;
            winner.rw    = d_rw;
            winner.size  = d_size;
            winner.wdata = d_wdata;
        end else begin
            winner.port  = PORT_I;
            winner.addr  = i_addr;
            winner.rw    = 1'b0;
            winner.size  = i_size;
            winner.wdata = '0;
        end
`ifdef MEM_ARB_ALIGN_CHK_EN
        winner.bad = is_misaligned(winner.addr[1:0], winner.size);
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg      <= IDLE;
            last_grant_reg <= ~INIT_PRIO_D;
            lat_reg        <= '0;
            bus_addr_reg   <= '0;
            bus_rw_reg     <= 1'b0;
            bus_size_reg   <= SZ_NONE;
            bus_wdata_reg  <= '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (|grant) begin
                        lat_reg        <= winner;
                        last_grant_reg <= winner.port;
                        // Rejected requests skip the bus entirely.
                        state_reg      <= winner.bad ? DONE : ADDR;
                    end
                end
                ADDR: begin
                    bus_addr_reg  <= lat_reg.addr;
                    bus_rw_reg    <= lat_reg.rw;
                    bus_size_reg  <= lat_reg.size;
                    bus_wdata_reg <= lat_reg.wdata;
                    state_reg     <= lat_reg.rw ? DONE : RESP;
                end
                RESP: begin
                    state_reg <= DONE;
                end
                DONE: begin
                    bus_addr_reg  <= '0;
                    bus_rw_reg    <= 1'b0;
                    bus_size_reg  <= SZ_NONE;
                    bus_wdata_reg <= '0;
                    state_reg     <= IDLE;
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    // Per-port completion pulse and read-data holding register.
    genvar gi;
    generate
        for (gi = 0; gi < NUM_PORTS; gi++) begin : g_port
            localparam logic PID = (gi == 1);
            logic        ack_reg;
            logic [31:0] rdata_reg;
            logic        mine;

            assign mine = (lat_reg.port == PID);

            always_ff @(posedge clk) begin
                if (rst) begin
                    ack_reg   <= 1'b0;
                    rdata_reg <= '0;
                end else begin
                    ack_reg <= (state_reg == DONE) && mine;
                    if ((state_reg == RESP) && mine) begin
                        rdata_reg <= bus_rdata;
                    end else if ((state_reg == DONE) && mine && lat_reg.bad && !lat_reg.rw) begin
                        rdata_reg <= '0;
                    end
                end
            end
        end
    endgenerate

    assign i_ack   = g_port[0].ack_reg;
    assign i_rdata = g_port[0].rdata_reg;
    assign d_ack   = g_port[1].ack_reg;
    assign d_rdata = g_port[1].rdata_reg;

`ifdef MEM_ARB_ALIGN_CHK_EN
    logic err_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            err_reg <= 1'b0;
        end else begin
            err_reg <= (state_reg == DONE) && lat_reg.bad;
        end
    end

    assign err = err_reg;
`else
    assign err = 1'b0;
`endif

    assign bus_addr  = bus_addr_reg;
    assign bus_rw    = bus_rw_reg;
    assign bus_size  = bus_size_reg;
    assign bus_wdata = bus_wdata_reg;

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: a rule-level model predicts service order,
// ack cycle, rdata and err; monitors compare acks and bus activity.
`timescale 1ns/1ps
module tb_mem_arbiter;
    import mem_arb_pkg::*;

`ifdef MEM_ARB_ALIGN_CHK_EN
    localparam bit ALIGN_CHK = 1'b1;
`else
    localparam bit ALIGN_CHK = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        i_req, d_req, d_rw, i_ack, d_ack, err, bus_rw;
    logic [31:0] i_addr, d_addr, d_wdata, i_rdata, d_rdata;
    logic [31:0] bus_addr, bus_wdata, bus_rdata;
    logic [1:0]  i_size, d_size, bus_size;

    always #5 clk = ~clk;

    mem_arbiter dut (
        .clk(clk), .rst(rst),
        .i_req(i_req), .i_addr(i_addr), .i_size(i_size), .i_ack(i_ack), .i_rdata(i_rdata),
        .d_req(d_req), .d_addr(d_addr), .d_rw(d_rw), .d_size(d_size), .d_wdata(d_wdata),
        .d_ack(d_ack), .d_rdata(d_rdata), .err(err),
        .bus_addr(bus_addr), .bus_rw(bus_rw), .bus_size(bus_size), .bus_wdata(bus_wdata),
        .bus_rdata(bus_rdata)
    );

    // Slave: read data is a fixed function of the address.
    function automatic logic [31:0] slave_val(input logic [31:0] a);
        if (a == 32'h0) return 32'h800000b7;
        return {a[15:0], a[31:16]} ^ 32'h3C5A_A5C3;
    endfunction
    assign bus_rdata = slave_val(bus_addr);

    typedef struct { logic port; logic [31:0] rdata; logic err; int ack_cyc; } exp_t;
    typedef struct { logic [31:0] addr; logic rw; logic [1:0] size; logic [31:0] wdata; int len; } bus_t;

    exp_t        exp_q[$];
    bus_t        bus_q[$];
    int          cyc = 0;
    int          tests = 0;
    int          fails = 0;
    bit          mon_en = 1'b0;
    logic        last_served;
    logic [31:0] last_rd [2];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: actual=%h required=%h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic bit model_bad(input logic [31:0] a, input logic [1:0] sz);
        bit rule;
        rule = (sz == 2'b00) || (sz == 2'b10 && (a % 2) != 0) || (sz == 2'b11 && (a % 4) != 0);
        return ALIGN_CHK && rule;
    endfunction

    // Model one granted request; t advances to the cycle its ack appears.
    task automatic model_serve(input logic port, input logic [31:0] a, input logic rw,
                               input logic [1:0] sz, input logic [31:0] wd, inout int t);
        exp_t e;
        bus_t b;
        bit   bad;
        bad = model_bad(a, sz);
        t = t + (bad ? 2 : (rw ? 3 : 4));
        e.port = port;
        e.err = bad;
        e.ack_cyc = t;
        if (rw) e.rdata = last_rd[port];
        else    e.rdata = bad ? 32'h0 : slave_val(a);
        last_rd[port] = e.rdata;
        if (!bad) begin
            b.addr = a; b.rw = rw; b.size = sz; b.wdata = wd; b.len = rw ? 1 : 2;
            bus_q.push_back(b);
        end
        exp_q.push_back(e);
        last_served = port;
    endtask

    task automatic run_txn(input bit use_i, input bit use_d, input logic [31:0] ia, input logic [1:0] isz,
                           input logic [31:0] da, input logic drw, input logic [1:0] dsz,
                           input logic [31:0] dwd, input bit drop);
        int t, k;
        bit i_done, d_done;
        t = cyc;
        if (use_i && use_d) begin
            if (last_served == PORT_I) begin
                model_serve(PORT_D, da, drw, dsz, dwd, t);
                model_serve(PORT_I, ia, 1'b0, isz, 32'h0, t);
            end else begin
                model_serve(PORT_I, ia, 1'b0, isz, 32'h0, t);
                model_serve(PORT_D, da, drw, dsz, dwd, t);
            end
        end else if (use_i) begin
            model_serve(PORT_I, ia, 1'b0, isz, 32'h0, t);
        end else begin
            model_serve(PORT_D, da, drw, dsz, dwd, t);
        end
        i_req = use_i; i_addr = ia; i_size = isz;
        d_req = use_d; d_addr = da; d_rw = drw; d_size = dsz; d_wdata = dwd;
        i_done = !use_i;
        d_done = !use_d;
        k = 0;
        while (!(i_done && d_done) && k < 40) begin
            @(negedge clk);
            k++;
            if (drop && k == 1) begin
                i_req = 1'b0; d_req = 1'b0;
                i_addr = $urandom; d_addr = $urandom; d_wdata = $urandom;
                d_rw = ~d_rw; i_size = ~i_size; d_size = ~d_size;
            end
            if (i_ack) begin i_req = 1'b0; i_done = 1'b1; end
            if (d_ack) begin d_req = 1'b0; d_done = 1'b1; end
        end
        tests++;
        if (!(i_done && d_done)) begin
            fails++;
            $display("FAIL txn_timeout: acks i=%0b d=%0b after %0d cycles, required both", i_done, d_done, k);
            i_req = 1'b0; d_req = 1'b0;
        end
    endtask

    // Ack monitor: pops the next predicted completion whenever an ack shows.
    always @(negedge clk) begin
        if (mon_en) begin
            if (i_ack || d_ack) begin
                chk("ack_exclusive", {31'b0, i_ack & d_ack}, 32'h0);
                if (exp_q.size() == 0) begin
                    tests++; fails++;
                    $display("FAIL ack_unexpected: i_ack=%0b d_ack=%0b, required none", i_ack, d_ack);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    $display("[TB] ack port=%s rdata=%h err=%0b cycle=%0d", d_ack ? "D" : "I",
                             d_ack ? d_rdata : i_rdata, err, cyc);
                    chk("ack_port", {31'b0, d_ack}, {31'b0, e.port});
                    chk("ack_rdata", d_ack ? d_rdata : i_rdata, e.rdata);
                    chk("ack_err", {31'b0, err}, {31'b0, e.err});
                    chk("ack_cycle", cyc, e.ack_cyc);
                end
            end else begin
                chk("err_without_ack", {31'b0, err}, 32'h0);
            end
        end
    end

    // Bus monitor: each activity run must match the next predicted access.
    bus_t cur;
    int   b_run = 0;
    always @(negedge clk) begin
        if (!mon_en) begin
            b_run = 0;
        end else if ((bus_addr != 0) || bus_rw || (bus_size != 0)) begin
            if (b_run == 0) begin
                if (bus_q.size() == 0) begin
                    tests++; fails++;
                    $display("FAIL bus_unexpected: addr=%h rw=%0b size=%0d, required idle", bus_addr, bus_rw, bus_size);
                    cur.addr = bus_addr; cur.rw = bus_rw; cur.size = bus_size; cur.wdata = bus_wdata; cur.len = 0;
                end else begin
                    cur = bus_q.pop_front();
                end
            end
            chk("bus_addr", bus_addr, cur.addr);
            chk("bus_rw", {31'b0, bus_rw}, {31'b0, cur.rw});
            chk("bus_size", {30'b0, bus_size}, {30'b0, cur.size});
            if (cur.rw) chk("bus_wdata", bus_wdata, cur.wdata);
            b_run++;
        end else if (b_run != 0) begin
            chk("bus_active_cycles", b_run, cur.len);
            b_run = 0;
        end
    end

    task automatic chk_reset_values(input string tag);
        chk({tag, "_i_ack"}, {31'b0, i_ack}, 32'h0);
        chk({tag, "_d_ack"}, {31'b0, d_ack}, 32'h0);
        chk({tag, "_err"}, {31'b0, err}, 32'h0);
        chk({tag, "_i_rdata"}, i_rdata, 32'h0);
        chk({tag, "_d_rdata"}, d_rdata, 32'h0);
        chk({tag, "_bus_addr"}, bus_addr, 32'h0);
        chk({tag, "_bus_rw"}, {31'b0, bus_rw}, 32'h0);
        chk({tag, "_bus_size"}, {30'b0, bus_size}, 32'h0);
        chk({tag, "_bus_wdata"}, bus_wdata, 32'h0);
    endtask

    function automatic logic [31:0] rnd_addr();
        logic [31:0] a;
        a = $urandom;
        if ($urandom_range(0, 1) == 1) a[1:0] = 2'b00;
        if (a == 32'h0) a = 32'h10;
        return a;
    endfunction

    task automatic model_reset();
        last_served = ~1'b1;  // opposite of the default INIT_PRIO_D
        last_rd[0] = 32'h0;
        last_rd[1] = 32'h0;
    endtask

    initial begin : watchdog
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        int ack_seen;
        rst = 1'b1;
        i_req = 1'b0; i_addr = '0; i_size = '0;
        d_req = 1'b0; d_addr = '0; d_rw = 1'b0; d_size = '0; d_wdata = '0;
        model_reset();
        repeat (3) @(negedge clk);
        chk_reset_values("reset");
        rst = 1'b0;
        mon_en = 1'b1;
        @(negedge clk);

        // Simultaneous reads after reset: D first, then I.
        run_txn(1, 1, 32'h0000_0040, SZ_WORD, 32'h0000_0080, 1'b0, SZ_WORD, 32'h0, 0);
        run_txn(1, 1, 32'h0000_0044, SZ_WORD, 32'h0000_0084, 1'b0, SZ_WORD, 32'h0, 0);
        // Lone fetch from address 0.
        run_txn(1, 0, 32'h0, SZ_WORD, 32'h0, 1'b0, SZ_NONE, 32'h0, 0);
        // Data write.
        run_txn(0, 1, 32'h0, SZ_NONE, 32'h8000_0004, 1'b1, SZ_WORD, 32'h5, 0);
        // Misaligned word read.
        run_txn(0, 1, 32'h0, SZ_NONE, 32'h0000_0002, 1'b0, SZ_WORD, 32'h0, 0);
        // Fetch whose request drops after one cycle.
        run_txn(1, 0, 32'h0000_1000, SZ_HALF, 32'h0, 1'b0, SZ_NONE, 32'h0, 1);

        for (int n = 0; n < 150; n++) begin
            int kind;
            logic [31:0] ia, da, dwd;
            logic [1:0]  isz, dsz;
            logic        drw;
            bit          drop;
            kind = $urandom_range(0, 2);
            ia = rnd_addr(); isz = 2'($urandom_range(0, 3));
            da = rnd_addr(); dsz = 2'($urandom_range(0, 3));
            drw = 1'($urandom_range(0, 1)); dwd = $urandom;
            drop = (kind != 2) && ($urandom_range(0, 3) == 0);
            run_txn(kind != 1, kind != 0, ia, isz, da, drw, dsz, dwd, drop);
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end

        // Reset during RESP of a fetch read aborts it without an ack.
        repeat (2) @(negedge clk);
        mon_en = 1'b0;
        i_req = 1'b1; i_addr = 32'h0000_0100; i_size = SZ_WORD;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk_reset_values("midreset");
        rst = 1'b0;
        i_req = 1'b0;
        ack_seen = 0;
        repeat (8) begin
            @(negedge clk);
            if (i_ack || d_ack) ack_seen++;
        end
        chk("midreset_no_ack", ack_seen, 0);
        model_reset();
        mon_en = 1'b1;
        @(negedge clk);
        run_txn(1, 0, 32'h0000_0200, SZ_WORD, 32'h0, 1'b0, SZ_NONE, 32'h0, 0);
        run_txn(1, 1, 32'h0000_0300, SZ_WORD, 32'h0000_0304, 1'b0, SZ_WORD, 32'h0, 0);

        repeat (6) @(negedge clk);
        chk("pending_acks", exp_q.size(), 0);
        chk("pending_bus", bus_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
